mult_mmio_ctrl: RTL and testbench
=================================

Name: mult_mmio_ctrl

Overview:
Memory-mapped controller that sequences the 32x32 LUT multiplier for the picorv32 core. It decodes the core's look-ahead bus (mem_la_*), holds the operand registers, and drives the multiplier sources. It counts the multiplier latency, captures the 64-bit product and exposes busy/done/error status plus a done interrupt pulse. It sits beside system memory decode; the multiplier stays a separate instance fed by this block.

Parameters:
BASE_ADDR, 32'h1000_0020, word-aligned base of a 32-byte register window.
MUL_LATENCY, 2, clock cycles from mul_src update to a valid mul_result (legal range 1..15).

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
la_read  input  1  core look-ahead read strobe
la_write  input  1  core look-ahead write strobe
la_addr  input  32  look-ahead byte address
la_wdata  input  32  look-ahead write data
la_wstrb  input  4  byte write enables
rdata  output  32  registered read data, valid the cycle after la_read
hit  output  1  registered; 1 the cycle after any la_read/la_write inside the window
mul_src0  output  32  multiplier operand A
mul_src1  output  32  multiplier operand B
mul_result  input  64  multiplier product
irq_done  output  1  one-cycle pulse when a product is captured

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (resetn). All flops clear on negedge resetn. Reset values: rdata=0, hit=0, mul_src0/1=0, irq_done=0, all registers 0, state IDLE.
- Register map (offset from BASE_ADDR):
  - 0x00 OP_A (RW). Byte-wise writes per la_wstrb.
  - 0x04 OP_B (RW). Byte-wise writes per la_wstrb.
  - 0x08 CTRL (W; reads 0). Bit0 START, bit1 CLR_DONE, bit2 CLR_ERR. Acted on only if la_wstrb[0].
  - 0x0C STATUS (RO). Bit0 busy, bit1 done, bit2 hi_nz (RES_HI != 0), bit3 err.
  - 0x10 RES_LO (RO).
  - 0x14 RES_HI (RO).
  - 0x18 and 0x1C read 0; writes to them are ignored.
- Address match is la_addr[31:5]==BASE_ADDR[31:5]; la_addr[1:0] is ignored.
- Reads: rdata is updated on the clock after la_read (1-cycle latency, matching FAST_MEMORY). It holds its value when there is no read hit.
- FSM states:
  - IDLE: START write -> LOAD.
  - LOAD: mul_src0<=OP_A, mul_src1<=OP_B; counter<=MUL_LATENCY-1; busy=1 -> WAIT.
  - WAIT: counter decrements each cycle. At counter==0: RES_LO/HI<=mul_result, done<=1, irq_done=1 for one cycle -> IDLE.
- Start-to-done: done is visible in STATUS exactly MUL_LATENCY+1 cycles after the START write edge.
- mul_src0/1 change only in LOAD and hold otherwise. RES_LO/HI keep the previous product until the next capture.
- Writes to OP_A, OP_B or START while busy are ignored and set err (sticky).
- CLR_DONE and CLR_ERR are honoured even while busy.
- START+CLR_DONE in the same write: done clears, then the operation starts (busy=1, done=0).
- CLR_DONE in the same cycle as capture: capture wins, done=1.
- START while done=1 with CLR_DONE=0 is legal and clears done on entry to LOAD.
- la_read and la_write never assert together (core guarantee); no priority logic is required.
- Reset mid-operation aborts with no irq; the next START behaves as after power-up.
- Arithmetic is unsigned; the product is taken unmodified from mul_result.

Decomposition:
- Include file mult_mmio_defs.vh:
  - Register offsets: OFS_OP_A, OFS_OP_B, OFS_CTRL, OFS_STATUS, OFS_RES_LO, OFS_RES_HI.
  - CTRL and STATUS bit indices.
  - FSM state encodings: ST_IDLE, ST_LOAD, ST_WAIT.
- No sub-module is needed; the block is one FSM plus a register file.
- lut_multiplier_32b_cond stays instantiated in system and connects via mul_src0/1 and mul_result.
- The bench uses a behavioural multiplier model with a MUL_LATENCY-cycle delay.

Test Plan:
- Basic multiply: write OP_A=7, OP_B=6, CTRL=1; poll STATUS. Expect busy=1 for MUL_LATENCY+1 cycles, then STATUS=0x2, RES_LO=42, RES_HI=0, and one irq_done pulse.
- Wide product: OP_A=OP_B=0xFFFF_FFFF, START. Expect RES_LO=0x0000_0001, RES_HI=0xFFFF_FFFE, STATUS=0x6.
- Busy protection: START, then write OP_A=5 and CTRL=1 while busy. Expect OP_A unchanged, err=1, a single irq_done, and the product of the original operands. Then write CTRL=4: expect err=0.
- Byte strobes: OP_A=0x1122_3344, then write 0xAABB_CCDD with wstrb=4'b0100. Expect OP_A=0x11BB_3344. A CTRL write with wstrb=4'b0010 does not start.
- Reset mid-op: START with 3x4, assert resetn low during WAIT. Expect all registers 0, no irq_done; a START after release yields 12.
- Done/clear race: issue CLR_DONE on the capture cycle. Expect done=1. Next, START+CLR_DONE in one write gives STATUS=0x1 the following cycle.

Source files
------------

// File: rtl/mult_mmio_ctrl_pkg.sv
// mult_mmio_ctrl_pkg: register map, control/status bits and FSM states of the multiplier controller
package mult_mmio_ctrl_pkg;
    localparam logic [4:0] OFS_OP_A   = 5'h00;
    localparam logic [4:0] OFS_OP_B   = 5'h04;
    localparam logic [4:0] OFS_CTRL   = 5'h08;
    localparam logic [4:0] OFS_STATUS = 5'h0C;
    localparam logic [4:0] OFS_RES_LO = 5'h10;
    localparam logic [4:0] OFS_RES_HI = 5'h14;
    localparam int CTRL_START    = 0;
    localparam int CTRL_CLR_DONE = 1;
    localparam int CTRL_CLR_ERR  = 2;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    localparam int STAT_HI_NZ = 2;
    localparam int STAT_ERR   = 3;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } state_e;
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i+:8] = be[i] ? wd[8*i+:8] : cur[8*i+:8];
        return res;
    endfunction
endpackage

// File: rtl/mult_mmio_ctrl.sv
// mult_mmio_ctrl: memory-mapped sequencer for an external pipelined 32x32 multiplier
module mult_mmio_ctrl
    import mult_mmio_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0020,
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        la_read,
    input  logic        la_write,
    input  logic [31:0] la_addr,
    input  logic [31:0] la_wdata,
    input  logic [3:0]  la_wstrb,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [31:0] mul_src0,
    output logic [31:0] mul_src1,
    input  logic [63:0] mul_result,
    output logic        irq_done
);
    localparam logic [3:0] CNT_INIT = 4'(MUL_LATENCY - 1);
    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [31:0] res_lo_q, res_hi_q, src0_q, src1_q, rdata_q, rd_val;
    logic        done_q, done_d, err_q, err_d, hit_q, irq_q;
    logic        sel, wr, rd, busy, ctrl_wr, start_req, start, op_wr_a, op_wr_b, capture;
    logic [4:0]  ofs;
    logic        unused_addr;
    assign unused_addr = ^la_addr[1:0];
    assign sel       = la_addr[31:5] == BASE_ADDR[31:5];
    assign wr        = la_write & sel;
    assign rd        = la_read & sel;
    assign ofs       = {la_addr[4:2], 2'b00};
    assign busy      = state_q != ST_IDLE;
    assign ctrl_wr   = wr && ofs == OFS_CTRL && la_wstrb[0];
    assign start_req = ctrl_wr && la_wdata[CTRL_START];
    assign start     = start_req && !busy;
    assign op_wr_a   = wr && ofs == OFS_OP_A;
    assign op_wr_b   = wr && ofs == OFS_OP_B;
    assign capture   = state_q == ST_WAIT && cnt_q == 4'd0;
    // Operand updates, sticky error and done flag; capture beats a simultaneous CLR_DONE
    always_comb begin
        op_a_d = (op_wr_a && !busy) ? merge_bytes(op_a_q, la_wdata, la_wstrb) : op_a_q;
        op_b_d = (op_wr_b && !busy) ? merge_bytes(op_b_q, la_wdata, la_wstrb) : op_b_q;
        err_d  = (busy && (op_wr_a || op_wr_b || start_req)) || (err_q && !(ctrl_wr && la_wdata[CTRL_CLR_ERR]));
        done_d = capture ? 1'b1 : (start || (ctrl_wr && la_wdata[CTRL_CLR_DONE])) ? 1'b0 : done_q;
        rd_val = ofs == OFS_OP_A   ? op_a_q :
                 ofs == OFS_OP_B   ? op_b_q :
                 ofs == OFS_STATUS ? {28'd0, err_q, |res_hi_q, done_q, busy} :
                 ofs == OFS_RES_LO ? res_lo_q :
                 ofs == OFS_RES_HI ? res_hi_q : 32'd0;
    end
    // Register file state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            op_a_q <= '0;
            op_b_q <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            err_q  <= err_d;
            done_q <= done_d;
        end
    end
    // Bus response: hit for any window access, read data held between read hits
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            hit_q <= (la_read || la_write) && sel;
            if (rd) rdata_q <= rd_val;
        end
    end
    // Sequencer: load operands, count multiplier latency, capture product and pulse irq
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            src0_q   <= '0;
            src1_q   <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (start) state_q <= ST_LOAD;
                ST_LOAD: begin
                    src0_q  <= op_a_q;
                    src1_q  <= op_b_q;
                    cnt_q   <= CNT_INIT;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (capture) begin
                        res_lo_q <= mul_result[31:0];
                        res_hi_q <= mul_result[63:32];
                        irq_q    <= 1'b1;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    assign rdata    = rdata_q;
    assign hit      = hit_q;
    assign mul_src0 = src0_q;
    assign mul_src1 = src1_q;
    assign irq_done = irq_q;
endmodule

// File: tb/tb_mult_mmio_ctrl.sv
// tb_mult_mmio_ctrl: table, random and corner-case checks of the multiplier MMIO controller
module tb_mult_mmio_ctrl;
    import mult_mmio_ctrl_pkg::*;
    localparam logic [31:0] BASE = 32'h1000_0020;
    localparam int L = 2;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
        logic [31:0] st;
    } vec_t;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        la_read = 1'b0, la_write = 1'b0;
    logic [31:0] la_addr = '0, la_wdata = '0;
    logic [3:0]  la_wstrb = '0;
    logic [31:0] rdata, mul_src0, mul_src1;
    logic        hit, irq_done;
    logic [63:0] mul_result;
    logic [63:0] pipe [L];
    int total = 0, bad = 0, irq_total = 0;
    vec_t tbl [6];

    mult_mmio_ctrl #(.BASE_ADDR(BASE), .MUL_LATENCY(L)) dut (
        .clk(clk), .resetn(resetn), .la_read(la_read), .la_write(la_write),
        .la_addr(la_addr), .la_wdata(la_wdata), .la_wstrb(la_wstrb),
        .rdata(rdata), .hit(hit), .mul_src0(mul_src0), .mul_src1(mul_src1),
        .mul_result(mul_result), .irq_done(irq_done)
    );

    always #5 clk = ~clk;

    // Multiplier model: product appears L cycles after the operands change, sampled on the capture edge
    always @(posedge clk) begin
        pipe[0] <= {32'd0, mul_src0} * {32'd0, mul_src1};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_result = pipe[L-2];

    always @(negedge clk) if (irq_done) irq_total++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [4:0] ofs, input logic [31:0] d, input logic [3:0] be = 4'hF);
        @(negedge clk);
        la_write = 1'b1; la_addr = BASE + {27'd0, ofs}; la_wdata = d; la_wstrb = be;
        @(posedge clk); #1;
        la_write = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] d);
        @(negedge clk);
        la_read = 1'b1; la_addr = addr;
        @(posedge clk); #1;
        la_read = 1'b0;
        d = rdata;
    endtask

    task automatic reg_rd(input logic [4:0] ofs, output logic [31:0] d);
        bus_rd(BASE + {27'd0, ofs}, d);
    endtask

    task automatic poll(output int busy_n, output logic [31:0] st);
        logic [31:0] s;
        busy_n = 0;
        s = '0;
        for (int k = 0; k < 20; k++) begin
            reg_rd(OFS_STATUS, s);
            if (!s[STAT_BUSY]) break;
            busy_n++;
        end
        st = s;
    endtask

    initial begin
        logic [31:0] d, st, a, a0, a1, b, lo, hi;
        logic [63:0] p;
        logic [3:0]  be;
        int n, irq0;
        tbl[0] = '{32'd7, 32'd6, 64'd42, 32'h2};
        tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32'h6};
        tbl[2] = '{32'h0, 32'h1234_5678, 64'h0, 32'h2};
        tbl[3] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 32'h6};
        tbl[4] = '{32'h8000_0000, 32'h3, 64'h0000_0001_8000_0000, 32'h6};
        tbl[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 32'h2};
        repeat (3) @(negedge clk);
        check("reset rdata", rdata, 0);
        check("reset hit", hit, 0);
        check("reset src0", mul_src0, 0);
        check("reset src1", mul_src1, 0);
        check("reset irq", irq_done, 0);
        resetn = 1'b1;
        reg_rd(OFS_STATUS, d);
        check("reset status", d, 0);
        check("status hit", hit, 1);
        // Decode window
        bus_wr(OFS_OP_A, 32'hDEAD_BEEF);
        reg_rd(OFS_OP_A, d);
        check("op_a readback", d, 32'hDEAD_BEEF);
        bus_rd(BASE + 32'h20, d);
        check("outside hit", hit, 0);
        check("outside rdata hold", d, 32'hDEAD_BEEF);
        bus_rd(BASE + 32'h1B, d);
        check("ofs 18 read", d, 0);
        check("ofs 18 hit", hit, 1);
        @(negedge clk);
        la_write = 1'b1; la_addr = BASE + 32'h20; la_wdata = 32'h5; la_wstrb = 4'hF;
        @(posedge clk); #1;
        la_write = 1'b0;
        check("outside write hit", hit, 0);
        reg_rd(OFS_OP_A, d);
        check("outside write ignored", d, 32'hDEAD_BEEF);
        reg_rd(OFS_CTRL, d);
        check("ctrl reads 0", d, 0);
        // Table of multiplies
        for (int t = 0; t < 6; t++) begin
            bus_wr(OFS_OP_A, tbl[t].a);
            bus_wr(OFS_OP_B, tbl[t].b);
            irq0 = irq_total;
            bus_wr(OFS_CTRL, 32'h1);
            poll(n, st);
            check($sformatf("tbl%0d busy cycles", t), n, L + 1);
            check($sformatf("tbl%0d status", t), st, tbl[t].st);
            reg_rd(OFS_RES_LO, lo);
            reg_rd(OFS_RES_HI, hi);
            check($sformatf("tbl%0d product", t), {hi, lo}, tbl[t].prod);
            check($sformatf("tbl%0d irq", t), irq_total - irq0, 1);
            reg_rd(OFS_OP_B, d);
            check($sformatf("tbl%0d op_b", t), d, tbl[t].b);
        end
        // Random operands with partial byte writes
        for (int t = 0; t < 20; t++) begin
            a0 = $urandom; a1 = $urandom; b = $urandom; be = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) a[8*k+:8] = be[k] ? a1[8*k+:8] : a0[8*k+:8];
            p = {32'd0, a} * {32'd0, b};
            bus_wr(OFS_OP_A, a0);
            bus_wr(OFS_OP_A, a1, be);
            bus_wr(OFS_OP_B, b);
            bus_wr(OFS_CTRL, 32'h1);
            poll(n, st);
            reg_rd(OFS_RES_LO, lo);
            reg_rd(OFS_RES_HI, hi);
            check($sformatf("rnd%0d product", t), {hi, lo}, p);
            check($sformatf("rnd%0d status", t), st, (p[63:32] != 0) ? 32'h6 : 32'h2);
        end
        // Writes while busy are dropped and flag err
        bus_wr(OFS_OP_A, 32'd3);
        bus_wr(OFS_OP_B, 32'd5);
        irq0 = irq_total;
        bus_wr(OFS_CTRL, 32'h1);
        bus_wr(OFS_OP_A, 32'd5);
        bus_wr(OFS_CTRL, 32'h1);
        poll(n, st);
        check("busy status", st, 32'hA);
        reg_rd(OFS_RES_LO, lo);
        check("busy product", lo, 15);
        reg_rd(OFS_OP_A, d);
        check("busy op_a kept", d, 3);
        check("busy irq", irq_total - irq0, 1);
        bus_wr(OFS_CTRL, 32'h4);
        reg_rd(OFS_STATUS, d);
        check("clr_err", d, 32'h2);
        // Byte strobes
        bus_wr(OFS_OP_A, 32'h1122_3344);
        bus_wr(OFS_OP_A, 32'hAABB_CCDD, 4'b0100);
        reg_rd(OFS_OP_A, d);
        check("byte strobe op_a", d, 32'h11BB_3344);
        bus_wr(OFS_CTRL, 32'h1, 4'b0010);
        reg_rd(OFS_STATUS, d);
        check("ctrl without wstrb0", d, 32'h2);
        // CLR_DONE on the capture edge loses, then START+CLR_DONE
        bus_wr(OFS_OP_A, 32'd2);
        bus_wr(OFS_OP_B, 32'd9);
        bus_wr(OFS_CTRL, 32'h1);
        repeat (L) @(posedge clk);
        bus_wr(OFS_CTRL, 32'h2);
        reg_rd(OFS_STATUS, d);
        check("race done kept", d, 32'h2);
        reg_rd(OFS_RES_LO, lo);
        check("race product", lo, 18);
        bus_wr(OFS_CTRL, 32'h3);
        reg_rd(OFS_STATUS, d);
        check("start+clr status", d, 32'h1);
        poll(n, st);
        check("start+clr done", st, 32'h2);
        // Reset during WAIT
        bus_wr(OFS_OP_A, 32'd3);
        bus_wr(OFS_OP_B, 32'd4);
        bus_wr(OFS_CTRL, 32'h1);
        @(posedge clk); #1;
        irq0 = irq_total;
        resetn = 1'b0;
        #1;
        check("midrst src0", mul_src0, 0);
        check("midrst rdata", rdata, 0);
        check("midrst hit", hit, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst no irq", irq_total - irq0, 0);
        reg_rd(OFS_OP_A, d);
        check("midrst op_a", d, 0);
        reg_rd(OFS_OP_B, d);
        check("midrst op_b", d, 0);
        reg_rd(OFS_STATUS, d);
        check("midrst status", d, 0);
        reg_rd(OFS_RES_LO, d);
        check("midrst res_lo", d, 0);
        reg_rd(OFS_RES_HI, d);
        check("midrst res_hi", d, 0);
        bus_wr(OFS_OP_A, 32'd3);
        bus_wr(OFS_OP_B, 32'd4);
        bus_wr(OFS_CTRL, 32'h1);
        poll(n, st);
        check("after rst busy cycles", n, L + 1);
        reg_rd(OFS_RES_LO, lo);
        check("after rst product", lo, 12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
